rom_arbiter: RTL

- Shares one combinational 16-entry x 2-bit lookup ROM between two requesters.
- Round-robin arbitration, registered ROM address, per-requester single-entry response buffer with valid/ready backpressure.
- Sits between the two consumer blocks and the ROM instance, and owns the ROM address bus exclusively.

---
 rtl/rom_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter sharing one combinational 16x2 lookup ROM between two requesters
// Optional macro ROM_SCAN_EN adds a full-ROM checksum scan (scan_start/scan_done/scan_sum).
module rom_arbiter #(
  parameter int AW = 4,
  parameter int DW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [DW-1:0]    rsp0_data,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [DW-1:0]    rsp1_data,
  input  logic             rsp1_ready,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic             busy
`ifdef ROM_SCAN_EN
  ,
  input  logic             scan_start,
  output logic             scan_done,
  output logic [AW+DW-1:0] scan_sum
`endif
);

`ifdef ROM_SCAN_EN
  typedef enum logic [1:0] {IDLE, LOOKUP, SCAN} state_t;
`else
  typedef enum logic {IDLE, LOOKUP} state_t;
`endif

  state_t          state_q;
  logic [AW-1:0]   rom_addr_q;
  logic            owner_q;
  logic            last_q;       // 1 = requester 1 was granted last, so requester 0 is favoured
  logic            busy_q;
  logic            rsp0_valid_q, rsp1_valid_q;
  logic [DW-1:0]   rsp0_data_q, rsp1_data_q;

  logic elig0, elig1, pick1, scan_go, can_grant;

  assign elig0 = req0_valid & ~rsp0_valid_q;
  assign elig1 = req1_valid & ~rsp1_valid_q;
  assign pick1 = elig1 & (~elig0 | ~last_q);

`ifdef ROM_SCAN_EN
  logic [AW+DW-1:0] acc_q, acc_d, scan_sum_q;
  logic             scan_done_q;
  assign acc_d   = acc_q + (AW+DW)'(rom_data);
  assign scan_go = (state_q == IDLE) & scan_start;
`else
  assign scan_go = 1'b0;
`endif

  // A starting scan pre-empts both requesters; ready is forced low while reset is held.
  assign can_grant  = rst_n & (state_q == IDLE) & ~scan_go;
  assign req0_ready = can_grant & elig0 & ~pick1;
  assign req1_ready = can_grant & pick1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
`ifdef ROM_SCAN_EN
      acc_q        <= '0;
      scan_sum_q   <= '0;
      scan_done_q  <= 1'b0;
`endif
    end else begin
      if (rsp0_valid_q && rsp0_ready) rsp0_valid_q <= 1'b0;
      if (rsp1_valid_q && rsp1_ready) rsp1_valid_q <= 1'b0;
`ifdef ROM_SCAN_EN
      scan_done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef ROM_SCAN_EN
          if (scan_go) begin
            rom_addr_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end else
`endif
          if (req0_valid && req0_ready) begin
            rom_addr_q <= req0_addr;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOOKUP;
          end else if (req1_valid && req1_ready) begin
            rom_addr_q <= req1_addr;
            owner_q    <= 1'b1;
            last_q     <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (owner_q) begin
            rsp1_data_q  <= rom_data;
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_data_q  <= rom_data;
            rsp0_valid_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
`ifdef ROM_SCAN_EN
        SCAN: begin
          if (rom_addr_q == {AW{1'b1}}) begin
            scan_sum_q  <= acc_d;
            scan_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            acc_q      <= acc_d;
            rom_addr_q <= rom_addr_q + AW'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr   = rom_addr_q;
  assign busy       = busy_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
`ifdef ROM_SCAN_EN
  assign scan_done  = scan_done_q;
  assign scan_sum   = scan_sum_q;
`endif

endmodule
